serial_subtractor: RTL and testbench

- Bit-serial subtractor: the inverse-direction companion to the team's 4-bit ripple adder (switch operands, LED result).
- Captures minuend A, subtrahend B and borrow-in on a start request, then computes A - B - Bin one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- Presents WIDTH-bit difference plus borrow-out with a one-cycle done pulse.
- Sits between board switches/keys (via a start edge detector) and LEDG, replacing the combinational adder path in the arithmetic lab design.

---
 rtl/serial_subtractor.sv | 114 +++++++++++
 tb/tb_serial_subtractor.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: A - B - Bin computed LSB first through one
// full-subtractor cell and a borrow flip-flop, result committed on completion.
module serial_subtractor #(
    parameter int WIDTH = 4,
    parameter int CW    = 3
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             x, y, dbit, bnext;
    logic [WIDTH:0]   sr_ext;
    logic [WIDTH-1:0] sr_next;

    assign x       = sa_q[0];
    assign y       = sb_q[0];
    assign dbit    = x ^ y ^ br_q;
    assign bnext   = (~x & y) | (~(x ^ y) & br_q);
    // Widened so the shift also works for WIDTH == 1
    assign sr_ext  = {dbit, sr_q};
    assign sr_next = sr_ext[WIDTH:1];

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = bin;
                    sr_d    = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sr_d  = sr_next;
                br_d  = bnext;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d  = sr_next;
                    bout_d  = bnext;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=4: expected {bout,diff}
// queued at stimulus time, popped and compared when done pulses.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         CLOCK_50 = 1'b0;
    logic         reset    = 1'b1;
    logic         start    = 1'b0;
    logic [W-1:0] a        = '0;
    logic [W-1:0] b        = '0;
    logic         bin      = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W:0] sbq[$];

    serial_subtractor #(.WIDTH(W), .CW(3)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .bout     (bout)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [W:0] model(input logic [W-1:0] ma,
                                         input logic [W-1:0] mb,
                                         input logic mbin);
        logic [W:0] r;
        r = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
        return r;
    endfunction

    // Drives one operation and reports what was observed; no checking here.
    task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic ibin,
                      output logic [W:0] got, output int lat,
                      output int bcnt, output bit held, output bit tmo);
        logic [W-1:0] pd;
        logic         pb;
        @(negedge CLOCK_50);
        pd    = diff;
        pb    = bout;
        a     = ia;
        b     = ib;
        bin   = ibin;
        start = 1'b1;
        sbq.push_back(model(ia, ib, ibin));
        @(posedge CLOCK_50);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        bin   = 1'($urandom);
        bcnt  = busy ? 1 : 0;
        held  = (diff === pd) && (bout === pb);
        tmo   = 1'b1;
        lat   = 0;
        got   = 'x;
        for (int n = 1; n <= 40; n++) begin
            @(posedge CLOCK_50);
            #1;
            if (busy) bcnt++;
            if (done) begin
                lat = n;
                tmo = 1'b0;
                got = {bout, diff};
                break;
            end
            if (diff !== pd || bout !== pb) held = 1'b0;
        end
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        #1;
        n_cmp++;
        if ({busy, done, bout, diff} !== '0) begin
            n_bad++;
            $display("FAIL reset_state got=%b want=%b",
                     {busy, done, bout, diff}, 7'b0);
        end
        @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [W-1:0] ta[4] = '{4'd9, 4'd5, 4'd0, 4'd15};
        logic [W-1:0] tb[4] = '{4'd5, 4'd9, 4'd0, 4'd15};
        logic         tc[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [W:0]   got, exp;
        int           lat, bcnt;
        bit           held, tmo;
        for (int i = 0; i < 4; i++) begin
            op(ta[i], tb[i], tc[i], got, lat, bcnt, held, tmo);
            exp = sbq.pop_front();
            n_cmp++;
            if (tmo) begin
                n_bad++;
                $display("FAIL basic_timeout[%0d] got=no_done want=done", i);
            end
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL basic_result[%0d] got=%b want=%b", i, got, exp);
            end
            n_cmp++;
            if (lat !== W) begin
                n_bad++;
                $display("FAIL basic_latency[%0d] got=%0d want=%0d", i, lat, W);
            end
            n_cmp++;
            if (bcnt !== W + 1) begin
                n_bad++;
                $display("FAIL basic_busy_cycles[%0d] got=%0d want=%0d",
                         i, bcnt, W + 1);
            end
            n_cmp++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_bad++;
                $display("FAIL basic_idle_after[%0d] got=%b%b want=00",
                         i, busy, done);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [W:0] got, exp;
        int         lat, bcnt;
        bit         held, tmo;
        for (int v = 0; v < 512; v++) begin
            op(W'(v >> 5), W'(v >> 1), 1'(v), got, lat, bcnt, held, tmo);
            exp = sbq.pop_front();
            n_cmp++;
            if (tmo || got !== exp) begin
                n_bad++;
                $display("FAIL exh_result a=%0d b=%0d bin=%0d got=%b want=%b",
                         v >> 5, (v >> 1) & 15, v & 1, got, exp);
            end
            n_cmp++;
            if (!held) begin
                n_bad++;
                $display("FAIL exh_hold a=%0d b=%0d bin=%0d got=changed want=held",
                         v >> 5, (v >> 1) & 15, v & 1);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [W:0] exp, got;
        int         pulses;
        @(negedge CLOCK_50);
        a     = 4'd10;
        b     = 4'd3;
        bin   = 1'b0;
        start = 1'b1;
        sbq.push_back(model(4'd10, 4'd3, 1'b0));
        @(posedge CLOCK_50);
        #1;
        start = 1'b0;
        pulses = 0;
        got    = 'x;
        @(posedge CLOCK_50);
        #1;
        a     = 4'd1;
        b     = 4'd8;
        bin   = 1'b1;
        start = 1'b1;
        @(posedge CLOCK_50);
        #1;
        start = 1'b0;
        for (int n = 0; n < 15; n++) begin
            if (done) begin
                pulses++;
                got = {bout, diff};
            end
            @(posedge CLOCK_50);
            #1;
        end
        exp = sbq.pop_front();
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL ignore_result got=%b want=%b", got, exp);
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_bad++;
            $display("FAIL ignore_pulses got=%0d want=1", pulses);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        @(negedge CLOCK_50);
        a     = 4'd7;
        b     = 4'd2;
        bin   = 1'b0;
        start = 1'b1;
        @(posedge CLOCK_50);
        #1;
        start = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #1;
        reset = 1'b1;
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        n_cmp++;
        if ({busy, done, bout, diff} !== '0) begin
            n_bad++;
            $display("FAIL midreset_state got=%b want=%b",
                     {busy, done, bout, diff}, 7'b0);
        end
        pulses = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge CLOCK_50);
            #1;
            if (done || busy) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++;
            $display("FAIL midreset_activity got=%0d want=0", pulses);
        end
    endtask

    task automatic test_back_to_back();
        logic [W:0] exp, got;
        int         last, pulses, bad_gap;
        @(negedge CLOCK_50);
        a     = 4'd12;
        b     = 4'd3;
        bin   = 1'b0;
        start = 1'b1;
        last    = -1;
        pulses  = 0;
        bad_gap = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge CLOCK_50);
            #1;
            if (done) begin
                sbq.push_back(model(4'd12, 4'd3, 1'b0));
                pulses++;
                if (last >= 0 && n - last != W + 2) bad_gap++;
                last = n;
                got = {bout, diff};
                exp = sbq.pop_front();
                n_cmp++;
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL b2b_result got=%b want=%b", got, exp);
                end
            end
        end
        start = 1'b0;
        n_cmp++;
        if (pulses !== 3) begin
            n_bad++;
            $display("FAIL b2b_pulses got=%0d want=3", pulses);
        end
        n_cmp++;
        if (bad_gap !== 0) begin
            n_bad++;
            $display("FAIL b2b_period got=%0d_bad_gaps want=0", bad_gap);
        end
        repeat (W + 3) @(posedge CLOCK_50);
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_drain got=%b want=0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_exhaustive();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
